// File: rtl/sti_dac_scheduler.sv
// sti_dac_scheduler: round-robin descriptor scheduler for the STI_DAC serializer.
// It issues one load per transfer, tracks completion, and closes on end-of-stream or a hung serializer.
`timescale 1ns/1ps
module sti_dac_scheduler #(
  parameter int NREQ = 4,
  parameter int IDW = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [16*NREQ-1:0] req_data,
  input  logic [2*NREQ-1:0] req_length,
  input  logic [NREQ-1:0]   req_fill,
  input  logic [NREQ-1:0]   req_msb,
  input  logic [NREQ-1:0]   req_low,
  input  logic [NREQ-1:0]   req_end,
  output logic [NREQ-1:0]   gnt,
  output logic              load,
  output logic [15:0]       pi_data,
  output logic [1:0]        pi_length,
  output logic              pi_fill,
  output logic              pi_msb,
  output logic              pi_low,
  output logic              pi_end,
  input  logic              so_valid,
  input  logic              pixel_wr,
  input  logic              pixel_finish,
  output logic              done_valid,
  output logic [IDW-1:0]    done_id,
  output logic              busy,
  output logic              closed,
  output logic              timeout_err,
  output logic [8:0]        pix_cnt
);
  localparam int WDW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, LOAD, WAIT_WR, WAIT_DONE, END_WAIT, GAP, CLOSED} state_t;
  state_t state, state_nx;
  logic [IDW-1:0] rr, cur, win;
  logic [NREQ-1:0] win_oh;
  logic [15:0] sel_data;
  logic [1:0] sel_len;
  logic sel_fill, sel_msb, sel_low, sel_end, found;
  logic [WDW-1:0] wd;
  logic waiting, wd_hit, fin, grant, unused_so_valid;
  assign unused_so_valid = so_valid;
  // Scanning downward lets the nearest requester after rr overwrite farther ones.
  always_comb begin
    int idx;
    idx = 0;
    win = '0;
    win_oh = '0;
    sel_data = '0;
    sel_len = '0;
    {sel_fill, sel_msb, sel_low, sel_end} = '0;
    found = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(rr) + k) % NREQ;
      if (req[idx]) begin
        found = 1'b1;
        win = IDW'(idx);
        win_oh = '0;
        win_oh[idx] = 1'b1;
        sel_data = req_data[16*idx +: 16];
        sel_len = req_length[2*idx +: 2];
        {sel_fill, sel_msb, sel_low, sel_end} = {req_fill[idx], req_msb[idx], req_low[idx], req_end[idx]};
      end
    end
  end
  assign waiting = state inside {WAIT_WR, WAIT_DONE, END_WAIT};
  assign wd_hit = waiting && wd == WDW'(TIMEOUT - 1);
  assign fin = (state == WAIT_DONE && !pixel_wr && !pi_end) || (state == END_WAIT && pixel_finish);
  assign grant = state == IDLE && !closed && found;
  always_ff @(posedge clk) state <= reset ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      state_nx = grant ? LOAD : IDLE;
      LOAD:      state_nx = WAIT_WR;
      WAIT_WR:   state_nx = wd_hit ? CLOSED : pixel_wr ? WAIT_DONE : WAIT_WR;
      WAIT_DONE: state_nx = fin ? GAP : wd_hit ? CLOSED : pixel_wr ? WAIT_DONE : END_WAIT;
      END_WAIT:  state_nx = (fin || wd_hit) ? CLOSED : END_WAIT;
      GAP:       state_nx = IDLE;
      default:   state_nx = CLOSED;
    endcase
  end
  always_comb busy = !(state inside {IDLE, CLOSED});
  always_ff @(posedge clk) begin
    if (reset) begin
      gnt <= '0;
      load <= 1'b0;
      {pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end} <= '0;
      done_valid <= 1'b0;
      done_id <= '0;
      closed <= 1'b0;
      timeout_err <= 1'b0;
      pix_cnt <= '0;
      wd <= '0;
      rr <= IDW'(NREQ - 1);
      cur <= '0;
    end else begin
      gnt <= grant ? win_oh : '0;
      load <= state == LOAD;
      done_valid <= fin || wd_hit;
      if (grant) begin
        {pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end} <= {sel_data, sel_len, sel_fill, sel_msb, sel_low, sel_end};
        rr <= win;
        cur <= win;
      end
      if (state == GAP) {pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end} <= '0;
      if (state == LOAD) begin
        wd <= '0;
        pix_cnt <= '0;
      end else if (waiting) begin
        wd <= wd + 1'b1;
        if (pixel_wr && pix_cnt != '1) pix_cnt <= pix_cnt + 1'b1;
      end
      if (fin || wd_hit) done_id <= cur;
      if (fin && state == END_WAIT) closed <= 1'b1;
      // A completion arriving on the timeout cycle takes precedence over the watchdog.
      if (wd_hit && !fin) begin
        closed <= 1'b1;
        timeout_err <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_sti_dac_scheduler.sv
// tb_sti_dac_scheduler: scheduler bench with a behavioural serializer and round-robin model.
`timescale 1ns/1ps
module tb_sti_dac_scheduler;
  logic clk, reset;
  logic [3:0] req, w_req, gnt, w_gnt;
  logic [15:0] d_data [4];
  logic [1:0] d_len [4];
  logic [3:0] d_fill, d_msb, d_low, d_end;
  logic [63:0] req_data;
  logic [7:0] req_length;
  logic load, w_load, pi_fill, pi_msb, pi_low, pi_end, w_pi_fill, w_pi_msb, w_pi_low, w_pi_end;
  logic [15:0] pi_data, w_pi_data;
  logic [1:0] pi_length, w_pi_length, done_id, w_done_id;
  logic so_valid, pixel_wr, pixel_finish;
  logic done_valid, busy, closed, timeout_err, w_done_valid, w_busy, w_closed, w_timeout_err;
  logic [8:0] pix_cnt, w_pix_cnt;
  int tests, fails, cyc, m_rr, t_gnt, t_done;
  int ser_t, ser_n, ser_d;
  bit ser_act, ser_e, fin_seen;
  assign req_data = {d_data[3], d_data[2], d_data[1], d_data[0]};
  assign req_length = {d_len[3], d_len[2], d_len[1], d_len[0]};
  sti_dac_scheduler dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_length(req_length),
    .req_fill(d_fill), .req_msb(d_msb), .req_low(d_low), .req_end(d_end), .gnt(gnt), .load(load),
    .pi_data(pi_data), .pi_length(pi_length), .pi_fill(pi_fill), .pi_msb(pi_msb), .pi_low(pi_low),
    .pi_end(pi_end), .so_valid(so_valid), .pixel_wr(pixel_wr), .pixel_finish(pixel_finish),
    .done_valid(done_valid), .done_id(done_id), .busy(busy), .closed(closed),
    .timeout_err(timeout_err), .pix_cnt(pix_cnt));
  sti_dac_scheduler #(.TIMEOUT(20)) dut_wd (
    .clk(clk), .reset(reset), .req(w_req), .req_data(req_data), .req_length(req_length),
    .req_fill(d_fill), .req_msb(d_msb), .req_low(d_low), .req_end(d_end), .gnt(w_gnt), .load(w_load),
    .pi_data(w_pi_data), .pi_length(w_pi_length), .pi_fill(w_pi_fill), .pi_msb(w_pi_msb),
    .pi_low(w_pi_low), .pi_end(w_pi_end), .so_valid(1'b0), .pixel_wr(1'b0), .pixel_finish(1'b0),
    .done_valid(w_done_valid), .done_id(w_done_id), .busy(w_busy), .closed(w_closed),
    .timeout_err(w_timeout_err), .pix_cnt(w_pix_cnt));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Serializer: random start delay, 8 so_valid cycles per byte, then one pixel_wr cycle per byte.
  initial begin
    so_valid = 0; pixel_wr = 0; pixel_finish = 0; ser_act = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        ser_act = 0; so_valid = 0; pixel_wr = 0; pixel_finish = 0;
      end else if (load) begin
        ser_act = 1; ser_t = 0; ser_n = int'(pi_length) + 1; ser_e = pi_end;
        ser_d = $urandom_range(0, 2); fin_seen = 0;
      end else if (ser_act) begin
        ser_t++;
        so_valid = ser_t > ser_d && ser_t <= ser_d + 8*ser_n;
        pixel_wr = ser_t > ser_d + 8*ser_n && ser_t <= ser_d + 9*ser_n;
        pixel_finish = ser_e && ser_t == ser_d + 9*ser_n + 2;
        if (pixel_finish) fin_seen = 1;
        if (ser_t > ser_d + 9*ser_n + 3) ser_act = 0;
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end
  function automatic int pick(input logic [3:0] m);
    for (int k = 1; k <= 4; k++) if (m[(m_rr + k) % 4]) return (m_rr + k) % 4;
    return 0;
  endfunction
  task automatic do_reset;
    @(negedge clk); reset = 1;
    repeat (2) @(negedge clk);
    reset = 0; m_rr = 3;
  endtask
  task automatic rand_desc(input int i, input logic e);
    d_data[i] = 16'($urandom); d_len[i] = 2'($urandom);
    d_fill[i] = 1'($urandom); d_msb[i] = 1'($urandom); d_low[i] = 1'($urandom); d_end[i] = e;
  endtask
  task automatic expect_xfer(input int id, input bit drop);
    int k, loads, n;
    bit pi_bad;
    logic [21:0] exp_pi;
    n = int'(d_len[id]) + 1;
    exp_pi = {d_data[id], d_len[id], d_fill[id], d_msb[id], d_low[id], d_end[id]};
    k = 0;
    do begin @(negedge clk); k++; end while (gnt === 4'b0 && k < 20);
    tests++;
    if (gnt !== 4'(1 << id)) begin
      fails++; $display("FAIL gnt: got %b want %b", gnt, 4'(1 << id)); return;
    end
    t_gnt = cyc; m_rr = id;
    tests++;
    if ({pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end} !== exp_pi) begin
      fails++; $display("FAIL pi_fields: got %h want %h", {pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end}, exp_pi);
    end
    tests++;
    if (load !== 0 || busy !== 1) begin fails++; $display("FAIL gnt_cycle: load=%b busy=%b want 0/1", load, busy); end
    if (drop) req[id] = 0;
    @(negedge clk);
    tests++;
    if (load !== 1) begin fails++; $display("FAIL load: got %b want 1", load); end
    pi_bad = 0; loads = 0;
    for (k = 0; k < 400 && done_valid !== 1; k++) begin
      @(negedge clk);
      if (load) loads++;
      if ({pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end} !== exp_pi) pi_bad = 1;
    end
    tests++;
    if (done_valid !== 1) begin fails++; $display("FAIL done_wait: done_valid=%b want 1", done_valid); return; end
    t_done = cyc;
    tests++;
    if (pi_bad || loads != 0) begin fails++; $display("FAIL pi_stable: changed=%0d extra_loads=%0d want 0/0", pi_bad, loads); end
    tests++;
    if (done_id !== 2'(id)) begin fails++; $display("FAIL done_id: got %0d want %0d", done_id, id); end
    tests++;
    if (pix_cnt !== 9'(n)) begin fails++; $display("FAIL pix_cnt: got %0d want %0d", pix_cnt, n); end
    tests++;
    if (closed !== d_end[id] || timeout_err !== 0) begin
      fails++; $display("FAIL flags: closed=%b timeout_err=%b want %b/0", closed, timeout_err, d_end[id]);
    end
    if (d_end[id]) begin
      tests++;
      if (!fin_seen) begin fails++; $display("FAIL end_done: done before pixel_finish, want after"); end
    end
    @(negedge clk);
    tests++;
    if (done_valid !== 0 || busy !== 0 || (!d_end[id] && pi_data !== 16'h0)) begin
      fails++; $display("FAIL after_done: done=%b busy=%b pi_data=%h want 0/0/0", done_valid, busy, pi_data);
    end
  endtask
  task automatic test_reset;
    reset = 1; req = 0; w_req = 0; m_rr = 3;
    for (int i = 0; i < 4; i++) begin d_data[i] = 0; d_len[i] = 0; end
    {d_fill, d_msb, d_low, d_end} = '0;
    repeat (3) @(negedge clk);
    tests++;
    if ({gnt, load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end, done_valid, done_id, busy, closed, timeout_err, pix_cnt} !== '0) begin
      fails++; $display("FAIL reset_outputs: got nonzero want 0");
    end
    tests++;
    if ({w_gnt, w_load, w_done_valid, w_busy, w_closed, w_timeout_err} !== '0) begin
      fails++; $display("FAIL reset_wd_outputs: got nonzero want 0");
    end
    reset = 0;
  endtask
  task automatic test_single;
    do_reset;
    d_data[0] = 16'hA5C3; d_len[0] = 2'b00; d_low[0] = 1; d_msb[0] = 1; d_fill[0] = 0; d_end[0] = 0;
    req = 4'b0001;
    expect_xfer(0, 1);
  endtask
  task automatic test_round_robin;
    int order [5] = '{0, 1, 2, 3, 0};
    do_reset;
    for (int i = 0; i < 4; i++) begin rand_desc(i, 0); d_len[i] = 2'b01; end
    req = 4'b1111;
    for (int i = 0; i < 5; i++) expect_xfer(order[i], 0);
    req = 0;
  endtask
  task automatic test_32b;
    int td;
    do_reset;
    rand_desc(0, 0); d_len[0] = 2'b11; d_fill[0] = 0; d_msb[0] = 0;
    rand_desc(1, 0);
    req = 4'b0011;
    expect_xfer(0, 1);
    td = t_done;
    expect_xfer(1, 1);
    tests++;
    if (t_gnt - td !== 2) begin fails++; $display("FAIL gap: gnt %0d cycles after done want 2", t_gnt - td); end
  endtask
  task automatic test_random;
    do_reset;
    for (int r = 0; r < 10; r++) begin
      req = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) if (req[i]) rand_desc(i, 0);
      for (int g = 0; g < 4 && req != 0; g++) expect_xfer(pick(req), 1);
      req = 0;
    end
  endtask
  task automatic test_end_stream;
    int gc;
    do_reset;
    rand_desc(2, 1);
    req = 4'b0100;
    expect_xfer(2, 1);
    req = 4'b0001; gc = 0;
    repeat (20) begin @(negedge clk); if (gnt !== 0 || load !== 0) gc++; end
    tests++;
    if (gc != 0) begin fails++; $display("FAIL closed_grant: %0d grant cycles want 0", gc); end
    tests++;
    if (closed !== 1 || busy !== 0) begin fails++; $display("FAIL closed_state: closed=%b busy=%b want 1/0", closed, busy); end
    req = 0;
  endtask
  task automatic test_reset_mid;
    int k;
    do_reset;
    rand_desc(0, 0); d_len[0] = 2'b11; rand_desc(1, 0);
    req = 4'b0001;
    k = 0;
    do begin @(negedge clk); k++; end while (gnt === 4'b0 && k < 20);
    req = 0; k = 0;
    do begin @(negedge clk); k++; end while (pixel_wr !== 1 && k < 100);
    @(negedge clk);
    reset = 1; req[1] = 1;
    @(negedge clk);
    tests++;
    if ({gnt, load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end, done_valid, done_id, busy, closed, timeout_err, pix_cnt} !== '0) begin
      fails++; $display("FAIL reset_mid: outputs nonzero want 0");
    end
    @(negedge clk);
    tests++;
    if (done_valid !== 0 || busy !== 0) begin fails++; $display("FAIL reset_mid_hold: done=%b busy=%b want 0/0", done_valid, busy); end
    reset = 0; m_rr = 3;
    expect_xfer(1, 1);
  endtask
  task automatic test_watchdog;
    int k, tl;
    do_reset;
    w_req = 4'b0001; k = 0;
    do begin @(negedge clk); k++; end while (w_gnt === 4'b0 && k < 20);
    w_req = 0;
    @(negedge clk);
    tests++;
    if (w_load !== 1) begin fails++; $display("FAIL wd_load: got %b want 1", w_load); end
    tl = cyc;
    for (k = 0; k < 40 && w_done_valid !== 1; k++) @(negedge clk);
    tests++;
    if (w_done_valid !== 1 || cyc - tl !== 20) begin
      fails++; $display("FAIL wd_time: done=%b at load+%0d want 1 at load+20", w_done_valid, cyc - tl);
    end
    tests++;
    if (w_timeout_err !== 1 || w_closed !== 1 || w_done_id !== 0) begin
      fails++; $display("FAIL wd_flags: err=%b closed=%b id=%0d want 1/1/0", w_timeout_err, w_closed, w_done_id);
    end
    @(negedge clk);
    tests++;
    if (w_done_valid !== 0 || w_busy !== 0 || w_timeout_err !== 1) begin
      fails++; $display("FAIL wd_after: done=%b busy=%b err=%b want 0/0/1", w_done_valid, w_busy, w_timeout_err);
    end
  endtask
  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_32b;
    test_random;
    test_end_stream;
    test_reset_mid;
    test_watchdog;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
